pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Sequential consumer of the next-PC value in the multi-cycle CPU. It holds the architectural PC and issues instruction-memory fetches with a req/ready handshake.
- It latches the fetched instruction and presents it to the control unit, then advances the PC to PC+4 or a redirect target when the control unit retires the instruction.
- It replaces the free-running PC register at the front of the multi-cycle datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC / instruction-memory address width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; equals pc_out.
- imem_ready  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word from memory.
- ir_out  output  32  latched instruction register.
- ir_valid  output  1  ir_out holds an instruction not yet retired.
- ir_accept  input  1  control unit retires the current instruction this cycle.
- redirect_valid  input  1  next PC comes from redirect_pc (branch/jump); sampled only with ir_accept.
- redirect_pc  input  ADDR_W  branch/jump target.
- halt_req  input  1  stop fetching after the current instruction retires; sampled only with ir_accept.
- pc_out  output  ADDR_W  PC of the instruction being fetched or held.
- pc_plus4  output  ADDR_W  combinational pc_out+4, for the link register and branch base.
- halted  output  1  unit is in HALT.

Behaviour:
- Reset (RST=0, asynchronous, overrides everything):
  - pc=RESET_PC, state=FETCH, ir_out=0, ir_valid=0, halted=0.
  - imem_req is 0 while RST=0; it rises in FETCH after reset release.
- States: FETCH, HOLD, HALT. The state register is 2 bits; the unused encoding returns to FETCH on the next edge.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc, ir_valid=0.
  - pc and imem_addr stay stable until imem_ready=1.
  - On the edge where imem_ready=1: ir_out<=imem_rdata, ir_valid<=1, state<=HOLD.
  - Minimum latency: ready in the first req cycle gives ir_valid one cycle later.
  - imem_ready with imem_req=0 is ignored in every state.
- HOLD:
  - Outputs: imem_req=0, ir_valid=1. ir_out and pc are frozen while ir_accept=0, for any number of cycles.
  - On the edge where ir_accept=1:
    - pc<=redirect_pc with bits [1:0] forced to 0 if redirect_valid=1, else pc<=pc+4.
    - ir_valid<=0.
    - state<=HALT if halt_req=1, else FETCH.
  - redirect_valid and halt_req both set: the PC takes the redirect and then halts; pc_out shows the target.
- Inputs outside their sampling window: redirect_valid, halt_req and ir_accept are ignored in FETCH and HALT.
- HALT:
  - imem_req=0, ir_valid=0, halted=1.
  - pc holds; only reset exits.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W: 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
  - pc_plus4 uses the same wrap.
- Reset mid-fetch: imem_req drops the instant RST falls. Any imem_ready arriving during or just after reset is discarded.
- Back-to-back operation: a retire in HOLD is followed by FETCH on the next cycle. Steady-state with zero-wait memory is 2 cycles per instruction plus the control unit's HOLD time.

Test Plan:
- Reset release, memory ready on first req cycle returning 32'h2002_0005 → imem_addr=0 for 1 cycle; next cycle ir_valid=1, ir_out=32'h2002_0005, imem_req=0.
- Memory ready delayed 3 cycles → imem_req high 4 cycles with imem_addr constant at 0x0; ir_valid rises one cycle after ready.
- ir_accept without redirect at pc=0x0000_0008 → next FETCH at imem_addr=0x0000_000C; pc_plus4 during that FETCH=0x0000_0010.
- ir_accept with redirect_pc=0x0000_0043 → next fetch at 0x0000_0040. Repeat starting from pc=32'hFFFF_FFFC without redirect → next fetch at 0x0000_0000.
- halt_req with ir_accept → halted=1, imem_req=0 for 20 cycles, pc frozen. Toggling imem_ready, ir_accept and redirect_valid during HALT causes no change.
- RST pulsed low mid-FETCH at pc=0x0000_0020 → imem_req=0 immediately, ir_valid=0. After release, the fetch restarts at RESET_PC; a stale imem_ready during reset is not latched.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Front-end PC holder for the multi-cycle CPU: fetches the instruction at pc over a req/ready handshake,
// holds it in the IR until the control unit retires it, then steps to pc+4, a redirect target or HALT.
module pc_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_accept,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_HOLD  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic              r_halted;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_redirect_aligned;

  assign w_pc_plus4         = r_pc + ADDR_W'(4);
  assign w_redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir       <= imem_rdata;
            r_ir_valid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_accept) begin
            r_pc       <= redirect_valid ? w_redirect_aligned : w_pc_plus4;
            r_ir_valid <= 1'b0;
            if (halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          // Unused encoding: recover into a clean fetch of the current pc
          r_state    <= S_FETCH;
          r_ir_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  // Gated by RST so the request drops the instant reset asserts, not at the next edge
  assign imem_req  = RST && (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign ir_out    = r_ir;
  assign ir_valid  = r_ir_valid;
  assign halted    = r_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a phase-level reference model checked every cycle on the falling edge,
// plus literal expectations at the key points of each scenario.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_accept = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halted;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .ir_valid(ir_valid), .ir_accept(ir_accept),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for memory, 1 = instruction held, 2 = halted
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_phase = 0;
      m_pc    = 32'h0;
      m_ir    = 32'h0;
    end else if (m_phase == 0 && imem_ready) begin
      m_ir    = imem_rdata;
      m_phase = 1;
      $display("fetch  pc=%h instr=%h", m_pc, m_ir);
    end else if (m_phase == 1 && ir_accept) begin
      m_pc    = redirect_valid ? (redirect_pc & ~32'h3) : m_pc + 32'd4;
      m_phase = halt_req ? 2 : 0;
      $display("retire next_pc=%h halt=%0d", m_pc, m_phase == 2);
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk1("m_req",    imem_req, RST && m_phase == 0);
      chk1("m_valid",  ir_valid, m_phase == 1);
      chk1("m_halted", halted,   m_phase == 2);
      chk("m_addr",    imem_addr, m_pc);
      chk("m_pc",      pc_out,    m_pc);
      chk("m_pc4",     pc_plus4,  m_pc + 32'd4);
      chk("m_ir",      ir_out,    m_ir);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch_now(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic retire(input logic rv, input logic [31:0] rpc, input logic hlt);
    ir_accept      = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hlt;
    tick();
    ir_accept      = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    #1;
  endtask

  int req_cnt;

  initial begin
    repeat (2) tick();
    cmp_en = 1'b1;

    // Zero-wait first fetch
    RST = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h2002_0005;
    #1;
    chk1("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    imem_ready = 1'b0;
    chk1("t1_valid", ir_valid, 1'b1);
    chk("t1_ir", ir_out, 32'h2002_0005);
    chk1("t1_req_lo", imem_req, 1'b0);

    // Restart and fetch with three wait cycles
    RST = 1'b0;
    tick();
    RST = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      imem_ready = (i == 3);
      imem_rdata = 32'h1111_0000;
      #1;
      if (imem_req) req_cnt++;
      chk("t2_addr", imem_addr, 32'h0);
      chk1("t2_valid_lo", ir_valid, 1'b0);
      tick();
    end
    imem_ready = 1'b0;
    chk("t2_req_cycles", req_cnt, 32'd4);
    chk1("t2_valid", ir_valid, 1'b1);
    chk("t2_ir", ir_out, 32'h1111_0000);

    // Sequential advance 0 -> 4 -> 8 -> C
    retire(1'b0, 32'h0, 1'b0);
    fetch_now(32'hA000_0004);
    retire(1'b0, 32'h0, 1'b0);
    fetch_now(32'hA000_0008);
    chk("t3_pc8", pc_out, 32'h8);
    retire(1'b0, 32'h0, 1'b0);
    chk("t3_addr", imem_addr, 32'hC);
    chk("t3_pc4", pc_plus4, 32'h10);
    chk1("t3_req", imem_req, 1'b1);

    // Redirect alignment and wrap-around
    fetch_now(32'hA000_000C);
    retire(1'b1, 32'h0000_0043, 1'b0);
    chk("t4_redirect", imem_addr, 32'h40);
    fetch_now(32'hA000_0040);
    retire(1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("t4_top", imem_addr, 32'hFFFF_FFFC);
    chk("t4_pc4_wrap", pc_plus4, 32'h0);
    fetch_now(32'hA000_FFFC);
    retire(1'b0, 32'h0, 1'b0);
    chk("t4_wrap", imem_addr, 32'h0);

    // Reset in the middle of a fetch at 0x20 with a stale ready
    fetch_now(32'hA000_0000);
    retire(1'b1, 32'h0000_0020, 1'b0);
    chk("t5_addr", imem_addr, 32'h20);
    tick();
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    RST = 1'b0;
    #1;
    chk1("t5_req_drop", imem_req, 1'b0);
    chk1("t5_valid", ir_valid, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    imem_ready = 1'b0;
    #1;
    chk("t5_restart", imem_addr, 32'h0);
    chk1("t5_req_up", imem_req, 1'b1);
    tick();
    chk1("t5_no_stale", ir_valid, 1'b0);
    chk("t5_ir_clear", ir_out, 32'h0);

    // Redirect together with halt, then ignore everything for 20 cycles
    fetch_now(32'hB000_0000);
    retire(1'b1, 32'h0000_0103, 1'b1);
    chk1("t6_halted", halted, 1'b1);
    chk("t6_pc", pc_out, 32'h100);
    for (int i = 0; i < 20; i++) begin
      imem_ready     = 1'($urandom_range(0, 1));
      imem_rdata     = $urandom;
      ir_accept      = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      halt_req       = 1'($urandom_range(0, 1));
      #1;
      chk1("t6_req", imem_req, 1'b0);
      chk1("t6_hold_halt", halted, 1'b1);
      chk("t6_pc_frozen", pc_out, 32'h100);
      tick();
    end
    imem_ready = 1'b0;
    ir_accept  = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
